// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for the pipeline stages.
//   PC_W_DEF / INSN_W_DEF : default program-counter and instruction widths
//   NOP_INSN              : bubble instruction (addi x0, x0, 0)
//   stage_state_e         : occupancy state of a pipeline stage register
//   state_occ()           : number of held entries for a stage state
package cpu_pkg;

    localparam int          PC_W_DEF   = 32;
    localparam int          INSN_W_DEF = 32;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] state_occ(input stage_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// skid_buf: two-entry skid buffer with a registered up_ready.
// Ports:
//   clk, rst (async, active-high), flush (synchronous kill)
//   up_valid/up_ready/up_pc/up_data : upstream handshake and beat
//   dn_valid/dn_ready/dn_pc/dn_data : downstream handshake and head beat
//   occupancy                       : held entries (0..2)
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing held, dn_valid=0
// ONE   | main register holds the head beat
// FULL  | main holds the head, skid holds the next beat
module skid_buf
    import cpu_pkg::*;
#(
    parameter int                PC_W    = PC_W_DEF,
    parameter int                DATA_W  = INSN_W_DEF,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [PC_W-1:0]   up_pc,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [PC_W-1:0]   dn_pc,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    stage_state_e      state;
    logic              up_ready_q;
    logic [PC_W-1:0]   main_pc;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              issue;

    assign dn_valid  = (state != EMPTY);
    assign up_ready  = up_ready_q;
    assign accept    = up_valid & up_ready_q;
    assign issue     = dn_valid & dn_ready;
    assign occupancy = state_occ(state);

    // Outputs are masked rather than cleared so a stalled head never moves.
    assign dn_pc   = dn_valid ? main_pc   : '0;
    assign dn_data = dn_valid ? main_data : NOP_VAL;

    // up_ready_q always tracks (next state != FULL), so it is a pure flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            up_ready_q <= 1'b1;
            main_pc    <= '0;
            main_data  <= NOP_VAL;
            skid_pc    <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            up_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_pc   <= up_pc;
                        main_data <= up_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        main_pc   <= up_pc;
                        main_data <= up_data;
                    end else if (accept) begin
                        skid_pc    <= up_pc;
                        skid_data  <= up_data;
                        state      <= FULL;
                        up_ready_q <= 1'b0;
                    end else if (issue) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        main_pc    <= skid_pc;
                        main_data  <= skid_data;
                        state      <= ONE;
                        up_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    up_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register between two CPU stages.
// SKID=0 is a single register whose up_ready follows dn_ready combinationally;
// SKID=1 uses skid_buf so up_ready comes straight from a flop.
// Ports:
//   clk, rst (async, active-high), flush (synchronous kill)
//   up_valid/up_ready/up_pc/up_data : upstream handshake and beat
//   dn_valid/dn_ready/dn_pc/dn_data : downstream handshake and head beat
//   occupancy                       : held entries (0..2, max 1 when SKID=0)
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int                PC_W    = PC_W_DEF,
    parameter int                DATA_W  = INSN_W_DEF,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [PC_W-1:0]   up_pc,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [PC_W-1:0]   dn_pc,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    generate
        if (SKID == 1) begin : g_skid
            skid_buf #(
                .PC_W    (PC_W),
                .DATA_W  (DATA_W),
                .NOP_VAL (NOP_VAL)
            ) u_skid_buf (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .up_valid  (up_valid),
                .up_ready  (up_ready),
                .up_pc     (up_pc),
                .up_data   (up_data),
                .dn_valid  (dn_valid),
                .dn_ready  (dn_ready),
                .dn_pc     (dn_pc),
                .dn_data   (dn_data),
                .occupancy (occupancy)
            );
        end else begin : g_single
            logic              valid_q;
            logic [PC_W-1:0]   pc_q;
            logic [DATA_W-1:0] data_q;
            logic              accept;
            logic              issue;

            assign up_ready  = dn_ready | ~valid_q;
            assign accept    = up_valid & up_ready;
            assign issue     = valid_q & dn_ready;
            assign dn_valid  = valid_q;
            assign dn_pc     = valid_q ? pc_q   : '0;
            assign dn_data   = valid_q ? data_q : NOP_VAL;
            assign occupancy = {1'b0, valid_q};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    pc_q    <= '0;
                    data_q  <= NOP_VAL;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    pc_q    <= up_pc;
                    data_q  <= up_data;
                end else if (issue) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share the
// same stimulus. Each has a reference model that is just an ordered queue of
// beats with a capacity; the monitor compares the DUT against the queue head.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        up_valid;
    logic [31:0] up_pc;
    logic [31:0] up_data;
    logic        dn_ready;

    logic        up_ready_w  [2];
    logic        dn_valid_w  [2];
    logic [31:0] dn_pc_w     [2];
    logic [31:0] dn_data_w   [2];
    logic [1:0]  occ_w       [2];

    beat_t       mq [2][$];
    logic        exp_rdy [2];
    logic        acc [2];

    int          checks;
    int          errors;
    logic [31:0] next_pc;

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .SKID(0), .NOP_VAL(NOP)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready_w[0]), .up_pc(up_pc), .up_data(up_data),
        .dn_valid(dn_valid_w[0]), .dn_ready(dn_ready), .dn_pc(dn_pc_w[0]),
        .dn_data(dn_data_w[0]), .occupancy(occ_w[0])
    );

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .SKID(1), .NOP_VAL(NOP)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready_w[1]), .up_pc(up_pc), .up_data(up_data),
        .dn_valid(dn_valid_w[1]), .dn_ready(dn_ready), .dn_pc(dn_pc_w[1]),
        .dn_data(dn_data_w[1]), .occupancy(occ_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the falling edge.
    // SKID=1 capacity is 2 with up_ready from the previous cycle's occupancy;
    // SKID=0 capacity is 1 and it can refill in the same cycle it drains.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                n = mq[d].size();
                exp_rdy[d] = (d == 1) ? (n < 2) : (dn_ready || n == 0);
                chk($sformatf("up_ready[skid=%0d]", d), 32'(up_ready_w[d]), 32'(exp_rdy[d]));
                chk($sformatf("occupancy[skid=%0d]", d), 32'(occ_w[d]), 32'(n));
                if (n > 0) begin
                    chk($sformatf("dn_valid[skid=%0d]", d), 32'(dn_valid_w[d]), 32'd1);
                    chk($sformatf("dn_pc[skid=%0d]", d), dn_pc_w[d], mq[d][0].pc);
                    chk($sformatf("dn_data[skid=%0d]", d), dn_data_w[d], mq[d][0].data);
                    if (dn_ready) void'(mq[d].pop_front());
                end else begin
                    chk($sformatf("dn_valid[skid=%0d]", d), 32'(dn_valid_w[d]), 32'd0);
                    chk($sformatf("dn_pc[skid=%0d]", d), dn_pc_w[d], 32'd0);
                    chk($sformatf("dn_data[skid=%0d]", d), dn_data_w[d], NOP);
                end
            end
        end
    end

    // Drive one cycle of stimulus; the model is updated at the following edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rel_rst);
        beat_t b;
        @(negedge clk);
        up_valid = v;
        up_pc    = pc;
        up_data  = $urandom;
        dn_ready = rdy;
        flush    = fl;
        #2;
        for (int d = 0; d < 2; d++) acc[d] = v && exp_rdy[d];
        b.pc   = up_pc;
        b.data = up_data;
        #1;
        if (rel_rst) rst = 1'b0;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (fl) mq[d].delete();
            else if (acc[d]) mq[d].push_back(b);
        end
    endtask

    // Reset pulse strictly between edges; outputs must clear before the next edge.
    task automatic rst_pulse();
        @(negedge clk);
        up_valid = 1'b1;
        up_pc    = 32'h0000_0666;
        dn_ready = 1'b0;
        flush    = 1'b0;
        #4;
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pulse dn_valid[skid=%0d]", d), 32'(dn_valid_w[d]), 32'd0);
            chk($sformatf("rst_pulse dn_pc[skid=%0d]", d), dn_pc_w[d], 32'd0);
            chk($sformatf("rst_pulse dn_data[skid=%0d]", d), dn_data_w[d], NOP);
            chk($sformatf("rst_pulse occupancy[skid=%0d]", d), 32'(occ_w[d]), 32'd0);
            mq[d].delete();
        end
        chk("rst_pulse up_ready[skid=1]", 32'(up_ready_w[1]), 32'd1);
        up_valid = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        up_valid = 1'b0;
        up_pc    = '0;
        up_data  = '0;
        dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset dn_valid[skid=%0d]", d), 32'(dn_valid_w[d]), 32'd0);
            chk($sformatf("reset dn_pc[skid=%0d]", d), dn_pc_w[d], 32'd0);
            chk($sformatf("reset dn_data[skid=%0d]", d), dn_data_w[d], NOP);
            chk($sformatf("reset occupancy[skid=%0d]", d), 32'(occ_w[d]), 32'd0);
        end
        chk("reset up_ready[skid=1]", 32'(up_ready_w[1]), 32'd1);

        // Stream with dn_ready=1; the first accept lands on the edge right after release.
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);

        // Backpressure: fill, then drain in order.
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while full with a beat offered upstream.
        step(1'b1, 32'h2f0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2f4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush in the single-entry state with a simultaneous accept and issue.
        step(1'b1, 32'h310, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h314, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);

        // Stall stability with upstream pushing new beats.
        step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h404 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Async reset pulse while full.
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
        rst_pulse();
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        next_pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), next_pc, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0), 1'b0);
            next_pc = next_pc + 32'd4;
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
